ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, between decode (register read, immediate extension) and memory access. It decodes the current instruction word and produces two results. The first is the ALU or address result (including link addresses and HI/LO reads). The second is the next fetch address, which reflects jumps and branches. The datapath is combinational; the only state is the HI/LO register pair written by multiply/divide and move-to instructions.

---
 rtl/ex_stage.sv | 172 +++++++++++++++++
 tb/tb_ex_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: combinational ALU/branch unit plus HI/LO registers
module ex_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  input  logic [31:0] Ed32,
  input  logic [31:0] nextPC,
  output logic [31:0] Result,
  output logic [31:0] newPC
);

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [4:0]         rt;
  logic [31:0]        a;
  logic [31:0]        b;
  logic signed [31:0] b_s;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        hi_d;
  logic [31:0]        lo_d;
  logic               hi_we;
  logic               lo_we;
  logic [31:0]        seq_pc;
  logic [31:0]        br_pc;
  logic [31:0]        link_pc;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quo_s;
  logic [31:0]        rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  assign op      = Ins[31:26];
  assign funct   = Ins[5:0];
  assign rt      = Ins[20:16];
  assign a       = Rdata1;
  assign b       = Rdata2;
  assign b_s     = Rdata2;
  assign seq_pc  = nextPC + 32'd4;
  assign link_pc = nextPC + 32'd4;
  assign br_pc   = nextPC + {Ed32[29:0], 2'b00};

  assign prod_s = $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divide by zero yields all-ones quotient and leaves the dividend as remainder
  always_comb begin
    quo_s = 32'hFFFF_FFFF;
    rem_s = a;
    quo_u = 32'hFFFF_FFFF;
    rem_u = a;
    if (b != 32'd0) begin
      quo_s = $unsigned($signed(a) / $signed(b));
      rem_s = $unsigned($signed(a) % $signed(b));
      quo_u = a / b;
      rem_u = a % b;
    end
  end

  always_comb begin
    Result = 32'd0;
    newPC  = seq_pc;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    hi_d   = hi;
    lo_d   = lo;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: Result = a + b;
          6'h22, 6'h23: Result = a - b;
          6'h24:        Result = a & b;
          6'h25:        Result = a | b;
          6'h26:        Result = a ^ b;
          6'h27:        Result = ~(a | b);
          6'h2A:        Result = {31'd0, $signed(a) < $signed(b)};
          6'h2B:        Result = {31'd0, a < b};
          6'h00:        Result = b << Ed32[4:0];
          6'h02:        Result = b >> Ed32[4:0];
          6'h03:        Result = $unsigned(b_s >>> Ed32[4:0]);
          6'h04:        Result = b << a[4:0];
          6'h06:        Result = b >> a[4:0];
          6'h07:        Result = $unsigned(b_s >>> a[4:0]);
          6'h18: begin
            Result = prod_s[31:0];
            {hi_d, lo_d} = prod_s;
            hi_we = 1'b1;
            lo_we = 1'b1;
          end
          6'h19: begin
            Result = prod_u[31:0];
            {hi_d, lo_d} = prod_u;
            hi_we = 1'b1;
            lo_we = 1'b1;
          end
          6'h1A: begin
            Result = quo_s;
            lo_d   = quo_s;
            hi_d   = rem_s;
            hi_we  = 1'b1;
            lo_we  = 1'b1;
          end
          6'h1B: begin
            Result = quo_u;
            lo_d   = quo_u;
            hi_d   = rem_u;
            hi_we  = 1'b1;
            lo_we  = 1'b1;
          end
          6'h10: Result = hi;
          6'h12: Result = lo;
          6'h11: begin
            hi_d  = a;
            hi_we = 1'b1;
          end
          6'h13: begin
            lo_d  = a;
            lo_we = 1'b1;
          end
          6'h08: newPC = a;
          6'h09: begin
            newPC  = a;
            Result = link_pc;
          end
          default: ;
        endcase
      end
      6'h08, 6'h09: Result = a + Ed32;
      6'h0A:        Result = {31'd0, $signed(a) < $signed(Ed32)};
      6'h0B:        Result = {31'd0, a < Ed32};
      6'h0C:        Result = a & Ed32;
      6'h0D:        Result = a | Ed32;
      6'h0E:        Result = a ^ Ed32;
      6'h0F:        Result = {Ed32[15:0], 16'h0000};
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2B: Result = a + Ed32;
      6'h02: newPC = {nextPC[31:28], Ins[25:0], 2'b00};
      6'h03: begin
        newPC  = {nextPC[31:28], Ins[25:0], 2'b00};
        Result = link_pc;
      end
      6'h04: if (a == b) newPC = br_pc;
      6'h05: if (a != b) newPC = br_pc;
      6'h06: if ($signed(a) <= 0) newPC = br_pc;
      6'h07: if ($signed(a) > 0) newPC = br_pc;
      6'h01: begin
        // rt[0] selects BGEZ vs BLTZ; rt[4] marks the linking forms
        case (rt)
          5'h00, 5'h10: if (a[31]) newPC = br_pc;
          5'h01, 5'h11: if (!a[31]) newPC = br_pc;
          default: ;
        endcase
        if (rt == 5'h10 || rt == 5'h11) Result = link_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed table and HI/LO sequence bench for ex_stage
module tb_ex_stage;

  logic        CLK;
  logic        RST;
  logic [31:0] Ins;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] Ed32;
  logic [31:0] nextPC;
  logic [31:0] Result;
  logic [31:0] newPC;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ed;
    logic [31:0] npc;
    logic [31:0] exp_res;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  ex_stage dut (
    .CLK    (CLK),
    .RST    (RST),
    .Ins    (Ins),
    .Rdata1 (Rdata1),
    .Rdata2 (Rdata2),
    .Ed32   (Ed32),
    .nextPC (nextPC),
    .Result (Result),
    .newPC  (newPC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {26'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] r);
    return {o, 5'd0, r, 16'd0};
  endfunction

  function automatic void add(input string name, input logic [31:0] ins, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] ed, input logic [31:0] npc,
                              input logic [31:0] er, input logic [31:0] ep);
    vec_t v;
    v.name = name; v.ins = ins; v.a = a; v.b = b; v.ed = ed; v.npc = npc;
    v.exp_res = er; v.exp_pc = ep;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic [31:0] npc);
    @(negedge CLK);
    Ins = ins; Rdata1 = a; Rdata2 = b; Ed32 = ed; nextPC = npc;
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    RST = 1'b0;
    Ins = 32'd0; Rdata1 = 32'd0; Rdata2 = 32'd0; Ed32 = 32'd0; nextPC = 32'd0;

    add("add",     rtype(6'h20), 32'h5, 32'h3, 32'h0, 32'h4, 32'h8, 32'h8);
    add("sub",     rtype(6'h22), 32'h5, 32'h3, 32'h0, 32'h4, 32'h2, 32'h8);
    add("nor",     rtype(6'h27), 32'hF, 32'h3, 32'h0, 32'h4, 32'hFFFF_FFF0, 32'h8);
    add("slt_neg", rtype(6'h2A), 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'h4, 32'h0, 32'h8);
    add("slt_t",   rtype(6'h2A), 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h4, 32'h1, 32'h8);
    add("sltu",    rtype(6'h2B), 32'h3, 32'h1, 32'h0, 32'h4, 32'h0, 32'h8);
    add("sltu_f",  rtype(6'h2B), 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h4, 32'h0, 32'h8);
    add("sll",     rtype(6'h00), 32'h0, 32'h3, 32'h2, 32'h4, 32'hC, 32'h8);
    add("sra",     rtype(6'h03), 32'h0, 32'hFFFF_FFF0, 32'h2, 32'h4, 32'hFFFF_FFFC, 32'h8);
    add("srl",     rtype(6'h02), 32'h0, 32'hFFFF_FFF0, 32'h4, 32'h4, 32'h0FFF_FFFF, 32'h8);
    add("srav",    rtype(6'h07), 32'h2, 32'hFFFF_FFF0, 32'h0, 32'h4, 32'hFFFF_FFFC, 32'h8);
    add("undef_f", rtype(6'h3F), 32'h5, 32'h3, 32'h0, 32'h4, 32'h0, 32'h8);
    add("addi",    itype(6'h08, 5'd0), 32'h5, 32'h0, 32'h2, 32'h4, 32'h7, 32'h8);
    add("xori",    itype(6'h0E, 5'd0), 32'hF, 32'h0, 32'h3, 32'h4, 32'hC, 32'h8);
    add("lui",     itype(6'h0F, 5'd0), 32'h0, 32'h0, 32'h1234, 32'h4, 32'h1234_0000, 32'h8);
    add("lw",      itype(6'h23, 5'd0), 32'h1000, 32'h0, 32'h4, 32'h4, 32'h1004, 32'h8);
    add("sw",      itype(6'h2B, 5'd0), 32'h1000, 32'h0, 32'h4, 32'h4, 32'h1004, 32'h8);
    add("undef_o", itype(6'h3F, 5'd0), 32'h5, 32'h3, 32'h4, 32'h4, 32'h0, 32'h8);
    add("jr",      rtype(6'h08), 32'h1000, 32'h0, 32'h0, 32'h4, 32'h0, 32'h1000);
    add("jalr",    rtype(6'h09), 32'h2000, 32'h0, 32'h0, 32'h8, 32'hC, 32'h2000);
    add("j",       32'h0800_0400, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h1000);
    add("jal",     32'h0C00_0400, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC, 32'h1000);
    add("beq_t",   itype(6'h04, 5'd0), 32'h5, 32'h5, 32'h8, 32'h4, 32'h0, 32'h24);
    add("bne_t",   itype(6'h05, 5'd0), 32'h5, 32'h3, 32'h8, 32'h4, 32'h0, 32'h24);
    add("blez_t",  itype(6'h06, 5'd0), 32'h0, 32'h0, 32'h8, 32'h4, 32'h0, 32'h24);
    add("bgtz_t",  itype(6'h07, 5'd0), 32'h5, 32'h0, 32'h8, 32'h4, 32'h0, 32'h24);
    add("bltz_t",  itype(6'h01, 5'h00), 32'hFFFF_FFFF, 32'h0, 32'h8, 32'h4, 32'h0, 32'h24);
    add("bgez_t",  itype(6'h01, 5'h01), 32'h5, 32'h0, 32'h8, 32'h4, 32'h0, 32'h24);
    add("beq_n",   itype(6'h04, 5'd0), 32'h5, 32'h3, 32'h8, 32'h4, 32'h0, 32'h8);
    add("bgtz_n",  itype(6'h07, 5'd0), 32'hFFFF_FFFF, 32'h0, 32'h8, 32'h4, 32'h0, 32'h8);
    add("bltzal",  itype(6'h01, 5'h10), 32'hFFFF_FFFF, 32'h0, 32'h8, 32'h4, 32'h8, 32'h24);
    add("bgezal_n", itype(6'h01, 5'h11), 32'hFFFF_FFFF, 32'h0, 32'h8, 32'h4, 32'h8, 32'h8);

    // Reset state of HI/LO
    repeat (2) @(posedge CLK);
    drive(rtype(6'h10), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("rst_mfhi", Result, 32'h0);
    drive(rtype(6'h12), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("rst_mflo", Result, 32'h0);
    RST = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ins, vecs[i].a, vecs[i].b, vecs[i].ed, vecs[i].npc);
      chk({vecs[i].name, "_res"}, Result, vecs[i].exp_res);
      chk({vecs[i].name, "_pc"}, newPC, vecs[i].exp_pc);
    end

    // MULT then MFHI/MFLO after the edge
    drive(rtype(6'h18), 32'h5, 32'h3, 32'h0, 32'h4);
    chk("mult_res", Result, 32'hF);
    drive(rtype(6'h10), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("mult_hi", Result, 32'h0);
    drive(rtype(6'h12), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("mult_lo", Result, 32'hF);

    drive(rtype(6'h18), 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h4);
    chk("mults_res", Result, 32'hFFFF_FFFE);
    drive(rtype(6'h10), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("mults_hi", Result, 32'hFFFF_FFFF);

    drive(rtype(6'h19), 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h4);
    chk("multu_res", Result, 32'hFFFF_FFFE);
    drive(rtype(6'h10), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("multu_hi", Result, 32'h1);

    drive(rtype(6'h1A), 32'hF, 32'h3, 32'h0, 32'h4);
    chk("div_res", Result, 32'h5);
    drive(rtype(6'h10), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("div_hi", Result, 32'h0);
    drive(rtype(6'h12), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("div_lo", Result, 32'h5);

    drive(rtype(6'h1A), 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h4);
    chk("divs_res", Result, 32'hFFFF_FFFD);
    drive(rtype(6'h10), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("divs_hi", Result, 32'hFFFF_FFFF);

    drive(rtype(6'h1B), 32'h7, 32'h0, 32'h0, 32'h4);
    chk("div0_res", Result, 32'hFFFF_FFFF);
    drive(rtype(6'h10), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("div0_hi", Result, 32'h7);

    // MTHI; MFHI in the same cycle as the write still sees the old value
    drive(rtype(6'h11), 32'hABCD, 32'h0, 32'h0, 32'h4);
    chk("mthi_res", Result, 32'h0);
    drive(rtype(6'h10), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("mthi_hi", Result, 32'hABCD);
    drive(rtype(6'h13), 32'h1234, 32'h0, 32'h0, 32'h4);
    drive(rtype(6'h12), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("mtlo_lo", Result, 32'h1234);

    // Back-to-back writers: last edge wins
    drive(rtype(6'h13), 32'h1111, 32'h0, 32'h0, 32'h4);
    drive(rtype(6'h13), 32'h2222, 32'h0, 32'h0, 32'h4);
    drive(rtype(6'h12), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("b2b_lo", Result, 32'h2222);

    // Reset overrides a simultaneous write
    drive(rtype(6'h13), 32'h5555, 32'h0, 32'h0, 32'h4);
    RST = 1'b0;
    drive(rtype(6'h12), 32'h0, 32'h0, 32'h0, 32'h4);
    RST = 1'b1;
    chk("rstpri_lo", Result, 32'h0);
    drive(rtype(6'h10), 32'h0, 32'h0, 32'h0, 32'h4);
    chk("rstpri_hi", Result, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
